pc_seq_unit: RTL

PC_SEQ_UNIT -- requirements
Module: pc_seq_unit

---
 rtl/pc_pkg.sv | 13 +
 rtl/pc_ras.sv | 65 ++++++
 rtl/pc_seq_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the PC sequencer: next-PC operation encoding and default width.
package pc_pkg;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_JMP = 2'd2,
        SEL_RET = 2'd3
    } sel_e;

    localparam int ADDR_W_DEF = 32;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push onto a full stack overwrites the oldest entry.
// State advances on the falling edge of clk; the caller gates push/pop for stall.
module pc_ras #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               push_data_i,
    output logic [W-1:0]               top_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    import pc_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d;
    logic [PTR_W-1:0] top_idx;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // sp_q points at the next free slot; with DEPTH a power of two it wraps naturally,
    // so when full it points at the oldest entry and a push replaces it.
    assign top_idx = sp_q - PTR_W'(1);
    assign top_o   = mem_q[top_idx];
    assign count_o = cnt_q;
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);

    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        if (push_i) begin
            sp_d = sp_q + PTR_W'(1);
            if (!full_o) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop_i && !empty_o) begin
            sp_d  = top_idx;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(negedge clk) begin
        if (!reset && push_i) begin
            mem_q[sp_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer (SEQ/BR/JMP/RET), updating on the falling edge of clk.
// Define PC_RAS_EN to build the return-address stack; otherwise RET acts as SEQ.
module pc_seq_unit
    import pc_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int STEP      = 1,
    parameter int RESET_PC  = 0,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [1:0]        sel,
    input  logic              call,
    input  logic [ADDR_W-1:0] offset,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] Read_addr,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_err
);

    sel_e              op;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] ret_pc;

    assign op        = sel_e'(sel);
    assign seq_pc    = pc_q + ADDR_W'(STEP);
    assign Read_addr = pc_q;

`ifdef PC_RAS_EN
    logic                           push, pop;
    logic                           err_q, err_d;
    logic [ADDR_W-1:0]              ras_top;
    logic [$clog2(RAS_DEPTH+1)-1:0] ras_count_unused;

    assign push = !stall && call && (op == SEL_BR || op == SEL_JMP);
    assign pop  = !stall && (op == SEL_RET) && !ras_empty;

    pc_ras #(
        .W     (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (seq_pc),
        .top_o       (ras_top),
        .count_o     (ras_count_unused),
        .full_o      (ras_full),
        .empty_o     (ras_empty)
    );

    // Underflow falls through to the sequential address and is remembered until reset.
    assign ret_pc = ras_empty ? seq_pc : ras_top;
    assign err_d  = err_q || (!stall && ((op == SEL_RET && ras_empty) || (push && ras_full)));
    assign ras_err = err_q;

    always_ff @(negedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    logic unused_call;

    assign unused_call = call;
    assign ret_pc      = seq_pc;
    assign ras_empty   = 1'b1;
    assign ras_full    = 1'b0;
    assign ras_err     = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            case (op)
                SEL_SEQ: pc_d = seq_pc;
                SEL_BR:  pc_d = pc_q + offset;
                SEL_JMP: pc_d = target;
                SEL_RET: pc_d = ret_pc;
                default: pc_d = seq_pc;
            endcase
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            pc_q <= ADDR_W'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule
